// File: rtl/bp_me_burst_stream_arbiter.sv
// Round-robin arbiter merging N BedRock burst streams (header, then optional data beats
// terminated by last) onto one burst output stream. A grant is held for a whole message:
// once a header is offered it is frozen until accepted, and a has_data message keeps the
// grant until its last data beat is accepted, so beats from different messages never mix.
//
// Ports:
//   clk_i, reset_i                  clock, asynchronous active-high reset
//   in_header_i / _v_i / _ready_and_o / in_has_data_i   per-input header channels
//   in_data_i / _v_i / _ready_and_o / in_last_i         per-input data channels
//   out_header_o / _v_o / _ready_and_i / out_has_data_o merged header channel
//   out_data_o / _v_o / _ready_and_i / out_last_o       merged data channel
//   grant_o                         one-hot current grant (status)
module bp_me_burst_stream_arbiter #(
  parameter int unsigned num_inputs_p   = 2,
  parameter int unsigned header_width_p = 64,
  parameter int unsigned data_width_p   = 64
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_inputs_p*header_width_p-1:0] in_header_i,
  input  logic [num_inputs_p-1:0]                in_header_v_i,
  output logic [num_inputs_p-1:0]                in_header_ready_and_o,
  input  logic [num_inputs_p-1:0]                in_has_data_i,
  input  logic [num_inputs_p*data_width_p-1:0]   in_data_i,
  input  logic [num_inputs_p-1:0]                in_data_v_i,
  output logic [num_inputs_p-1:0]                in_data_ready_and_o,
  input  logic [num_inputs_p-1:0]                in_last_i,
  output logic [header_width_p-1:0]              out_header_o,
  output logic                                   out_header_v_o,
  input  logic                                   out_header_ready_and_i,
  output logic                                   out_has_data_o,
  output logic [data_width_p-1:0]                out_data_o,
  output logic                                   out_data_v_o,
  input  logic                                   out_data_ready_and_i,
  output logic                                   out_last_o,
  output logic [num_inputs_p-1:0]                grant_o
);

  localparam int unsigned IdxW = $clog2(num_inputs_p);
  typedef logic [IdxW-1:0] idx_t;

  typedef enum logic [1:0] {e_ready, e_header, e_data} state_e;

  state_e state_q;
  idx_t   grant_q;
  idx_t   ptr_q;

  idx_t sel;
  idx_t cand;
  idx_t g;
  logic any_v;
  logic hdr_fire;
  logic data_fire;

  // Increment with wrap at num_inputs_p-1 (works for non-power-of-two counts).
  function automatic idx_t inc_idx(idx_t i);
    return (i == idx_t'(num_inputs_p - 1)) ? '0 : i + idx_t'(1);
  endfunction

  // First valid header at or after the priority pointer, searching upward with wrap.
  always_comb begin
    sel   = '0;
    any_v = 1'b0;
    cand  = ptr_q;
    for (int i = 0; i < int'(num_inputs_p); i++) begin
      if (!any_v && in_header_v_i[cand]) begin
        sel   = cand;
        any_v = 1'b1;
      end
      cand = inc_idx(cand);
    end
  end

  // In e_ready the header passes through from the live selection; afterwards the grant is frozen.
  assign g = (state_q == e_ready) ? sel : grant_q;

  assign out_header_o   = in_header_i[int'(g)*header_width_p +: header_width_p];
  assign out_has_data_o = in_has_data_i[g];
  assign out_data_o     = in_data_i[int'(grant_q)*data_width_p +: data_width_p];
  assign out_last_o     = in_last_i[grant_q];

  always_comb begin
    out_header_v_o        = 1'b0;
    out_data_v_o          = 1'b0;
    in_header_ready_and_o = '0;
    in_data_ready_and_o   = '0;
    grant_o               = '0;
    if (!reset_i) begin
      case (state_q)
        e_ready: begin
          if (any_v) begin
            out_header_v_o             = 1'b1;
            in_header_ready_and_o[sel] = out_header_ready_and_i;
            grant_o[sel]               = 1'b1;
          end
        end
        e_header: begin
          out_header_v_o                 = in_header_v_i[grant_q];
          in_header_ready_and_o[grant_q] = out_header_ready_and_i;
          grant_o[grant_q]               = 1'b1;
        end
        e_data: begin
          out_data_v_o                 = in_data_v_i[grant_q];
          in_data_ready_and_o[grant_q] = out_data_ready_and_i;
          grant_o[grant_q]             = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hdr_fire  = out_header_v_o & out_header_ready_and_i;
  assign data_fire = out_data_v_o & out_data_ready_and_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_ready;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        e_ready: begin
          if (any_v) begin
            grant_q <= sel;
            if (hdr_fire) begin
              if (in_has_data_i[sel]) state_q <= e_data;
              else                    ptr_q   <= inc_idx(sel);
            end else begin
              state_q <= e_header;
            end
          end
        end
        e_header: begin
          if (hdr_fire) begin
            if (in_has_data_i[grant_q]) begin
              state_q <= e_data;
            end else begin
              state_q <= e_ready;
              ptr_q   <= inc_idx(grant_q);
            end
          end
        end
        e_data: begin
          if (data_fire && in_last_i[grant_q]) begin
            state_q <= e_ready;
            ptr_q   <= inc_idx(grant_q);
          end
        end
        default: state_q <= e_ready;
      endcase
    end
  end

endmodule
